// File: rtl/hex_scan_display.sv
// hex_scan_display
//   Multiplexed NDIG-digit hexadecimal 7-segment driver with a load
//   handshake, leading-zero blanking and whole-display blinking.
//   New data is staged in a pending register and moved to the display
//   register only at a frame boundary, so a frame is never torn.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous, active-high reset
//   load      capture request, honoured only while ready=1
//   data      4*NDIG bits, nibble i drives digit i (digit 0 = LS)
//   ready     high when a new load can be accepted
//   blank_lz  enable leading-zero blanking
//   blink_en  enable whole-display blinking
//   seg       active-low segments, seg[0]=a ... seg[6]=g
//   dig_en    active-high one-hot digit select
module hex_scan_display #(
  parameter int NDIG         = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] data,
  output logic              ready,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [NDIG-1:0]   dig_en
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [FW-1:0]     fcnt;
  logic              phase;
  logic [4*NDIG-1:0] disp;
  logic [4*NDIG-1:0] pend;

  logic              presc_term;
  logic              frame;
  logic [3:0]        nib;
  logic              lz_blank;
  logic              above_zero;
  logic              dark;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign presc_term = (presc == PRESC_LAST);
  // The idx wrap is the frame boundary; with NDIG=1 idx is always last.
  assign frame      = presc_term && (idx == IDX_LAST);

  // Scan timing: prescaler, digit index, frame counter and blink phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
      fcnt  <= '0;
      phase <= 1'b1;
    end else begin
      if (presc_term) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (frame) begin
        if (fcnt == FCNT_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt  <= fcnt + 1'b1;
        end
      end
    end
  end

  // Load handshake. An accepted load takes priority; since ready=1 in
  // that cycle, a coincident frame boundary cannot transfer anything and
  // the new data waits for the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= '0;
      disp  <= '0;
      ready <= 1'b1;
    end else if (load && ready) begin
      pend  <= data;
      ready <= 1'b0;
    end else if (frame && !ready) begin
      disp  <= pend;
      ready <= 1'b1;
    end
  end

  // Output decode. Walk from the top digit down so above_zero holds
  // "nibbles i..NDIG-1 are all zero" when digit i is visited.
  always_comb begin
    nib        = '0;
    lz_blank   = 1'b0;
    above_zero = 1'b1;
    dig_en     = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      above_zero = above_zero && (disp[4*i +: 4] == 4'd0);
      dig_en[i]  = (idx == IW'(i));
      if (idx == IW'(i)) begin
        nib      = disp[4*i +: 4];
        lz_blank = (i != 0) && above_zero;
      end
    end
    dark = (blink_en && !phase) || (blank_lz && lz_blank);
    seg  = dark ? 7'h7F : hex7(nib);
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display
//   Scoreboard bench for hex_scan_display (NDIG=4, SCAN_DIV=4,
//   BLINK_FRAMES=2). The driver advances a cycle-count based reference
//   model and queues the expected outputs; a negedge monitor pops and
//   compares them against the DUT.
module tb_hex_scan_display;

  localparam int N = 4;
  localparam int S = 4;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        ready;
  logic [6:0]  seg;
  logic [3:0]  dig_en;

  hex_scan_display #(.NDIG(N), .SCAN_DIV(S), .BLINK_FRAMES(B)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .ready(ready),
    .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .dig_en(dig_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       rdy;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                               7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                               7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: n = clock edges since reset release.
  int          n = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_ready = 1'b1;

  function automatic exp_t expect_now();
    int          idx;
    int          frames;
    logic        ph;
    logic [15:0] upper;
    exp_t        e;
    idx    = (n / S) % N;
    frames = n / (S * N);
    ph     = ((frames / B) % 2) == 0;
    upper  = m_disp >> (4 * idx);
    e.dig  = 4'(1 << idx);
    e.rdy  = m_ready;
    if ((blink_en && !ph) || (blank_lz && idx > 0 && upper == 16'd0))
      e.seg = 7'h7F;
    else
      e.seg = hex_tab[upper[3:0]];
    return e;
  endfunction

  task automatic step(input logic ld, input logic [15:0] d,
                      input logic blz, input logic ben, input logic r);
    @(posedge clk);
    if (!rst) begin
      if (load && m_ready) begin
        m_pend  = data;
        m_ready = 1'b0;
      end else if ((n % (S * N)) == S * N - 1 && !m_ready) begin
        m_disp  = m_pend;
        m_ready = 1'b1;
      end
      n++;
    end
    #1;
    load = ld; data = d; blank_lz = blz; blink_en = ben; rst = r;
    if (r) begin
      n = 0; m_disp = '0; m_pend = '0; m_ready = 1'b1;
    end
    q.push_back(expect_now());
  endtask

  task automatic idle(input int k, input logic blz, input logic ben);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0000, blz, ben, 1'b0);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s t=%0t got %h expected %h", name, $time, got, want);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("seg", int'(seg), int'(e.seg));
      check("dig_en", int'(dig_en), int'(e.dig));
      check("ready", int'(ready), int'(e.rdy));
    end
  end

  initial begin : driver
    logic        blz;
    logic        ben;
    logic [15:0] d;
    // Reset held, then plain scanning with a blank display.
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(20, 1'b0, 1'b0);
    // Mid-frame load, followed by loads that must be ignored.
    step(1'b1, 16'h12AF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    idle(36, 1'b0, 1'b0);
    // Leading-zero blanking.
    step(1'b1, 16'h0030, 1'b1, 1'b0, 1'b0);
    idle(40, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    idle(40, 1'b1, 1'b0);
    // Blinking over several half-periods.
    step(1'b1, 16'h9C5E, 1'b0, 1'b1, 1'b0);
    idle(140, 1'b0, 1'b1);
    // Reset one cycle after an accepted load.
    step(1'b1, 16'h4321, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    idle(50, 1'b0, 1'b0);
    // Randomized traffic.
    blz = 1'b0;
    ben = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 49) == 0) blz = ~blz;
      if ($urandom_range(0, 49) == 0) ben = ~ben;
      d = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(($urandom_range(0, 5) == 0), d, blz, ben,
           ($urandom_range(0, 299) == 0));
    end
    idle(2, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 Parameter NDIG, default 4: number of multiplexed hex digits, legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000: Clock cycles each digit stays selected, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, minimum 1.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 load  input  1  request to capture data; accepted only in a cycle where ready=1.
REQ-007 data  input  4*NDIG  digit values; nibble i (data[4i+3:4i]) drives digit i, digit 0 least significant.
REQ-008 ready  output  1  high when a new load can be accepted.
REQ-009 blank_lz  input  1  enables leading-zero blanking.
REQ-010 blink_en  input  1  enables whole-display blinking.
REQ-011 seg  output  7  active-low segment pattern, seg[0]=a ... seg[6]=g; 0 lights a segment.
REQ-012 dig_en  output  NDIG  active-high one-hot digit select.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps; at terminal count, digit index idx advances by 1.
REQ-014 idx wraps from NDIG-1 to 0; that wrap cycle is the frame boundary. With NDIG=1, every prescaler terminal count is a frame boundary.
REQ-015 dig_en = one-hot(idx) at all times, including while the display is blanked or blinked off.
REQ-016 seg and dig_en are combinational from registered state and change in the same cycle idx changes.
REQ-017 Hex decode, active-low, for 0..F: 40 79 24 30 19 12 02 78 00 10 08 03 46 21 06 0E (hex, seg[6:0]).
REQ-018 Load handshake: load=1 with ready=1 copies data into the pending register and clears ready on the next edge.
REQ-019 load with ready=0 is ignored; pending and the display are unchanged.
REQ-020 At the first frame boundary with ready=0, pending is copied into the display register and ready returns to 1. The display therefore never shows a partially updated frame.
REQ-021 Load accepted in the same cycle as a frame boundary: data goes to pending only; the transfer occurs at the following frame boundary.
REQ-022 Leading-zero blanking: with blank_lz=1, digit i (i>=1) is blanked when display nibbles i..NDIG-1 are all zero. Digit 0 is never blanked.
REQ-023 A blanked digit drives seg=7F.
REQ-024 Blink: a frame counter counts frame boundaries 0..BLINK_FRAMES-1; on each wrap it toggles the phase bit.
REQ-025 With blink_en=1 and phase=0, seg=7F for every digit.
REQ-026 With blink_en=0, phase still toggles but has no effect on seg.
REQ-027 blank_lz and blink_en are sampled combinationally and take effect immediately; neither affects the handshake.

Reset
REQ-028 Reset=1 forces, asynchronously: prescaler=0, idx=0, frame counter=0, phase=1, display=0, pending=0, ready=1.
REQ-029 During and after reset: dig_en=1 (digit 0 selected) and seg=40 (digit "0").
REQ-030 Reset asserted mid-handshake discards pending data; the display returns to all zeros.
REQ-031 After Reset deasserts, the first idx advance occurs SCAN_DIV cycles later.

Verification (NDIG=4, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-032 Reset, then run -> dig_en sequence 1,2,4,8,1 with each value held 4 cycles; seg=40 throughout.
REQ-033 load=1, data=16'h12AF, mid-frame -> ready=0 next cycle; the display changes at the next idx 3->0 wrap.
  After the change, seg is 0E/08/24/79 for digits 0..3 and ready=1.
REQ-034 load while ready=0 with data=16'hFFFF -> ignored; the display keeps the previously loaded value.
REQ-035 data=16'h0030 loaded, blank_lz=1 -> digits 3 and 2 show 7F, digit 1 shows 30, digit 0 shows 40.
  With data=16'h0000, digits 3..1 show 7F and digit 0 shows 40.
REQ-036 blink_en=1 -> seg alternates between normal and 7F every 2 frames (32 cycles); dig_en keeps scanning.
REQ-037 Reset pulsed one cycle after an accepted load -> ready=1 and seg=40 immediately, with no later display update.
